// File: rtl/gearbox_tx_if.sv
// Stream bundle between the alignment-marker stage, the 66b->64b TX gearbox and the PMA side.
// The slave modport is the gearbox view; the master modport is the upstream/test view.
interface gearbox_tx_if #(
  parameter int LANE_N = 4,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
);
  logic [LANE_N*HEAD_W-1:0] head_i;
  logic [LANE_N*DATA_W-1:0] data_i;
  logic                     ready_o;
  logic                     valid_o;
  logic [LANE_N*DATA_W-1:0] data_o;

  modport master (
    output head_i,
    output data_i,
    input  ready_o,
    input  valid_o,
    input  data_o
  );

  modport slave (
    input  head_i,
    input  data_i,
    output ready_o,
    output valid_o,
    output data_o
  );
endinterface

// File: rtl/gearbox_tx.sv
// Per-lane 66b->64b TX gearbox: 32 blocks in, 33 words out per period, one stall cycle to flush.
// Optional macro GEARBOX_TX_SEQ_O_EN exposes the shared sequence counter on seq_o with a range assertion.
module gearbox_tx #(
  parameter int LANE_N = 4,
  parameter int HEAD_W = 2,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                nreset,
`ifdef GEARBOX_TX_SEQ_O_EN
  output logic [5:0]          seq_o,
`endif
  gearbox_tx_if.slave         bus
);

  localparam int          BLK_W    = DATA_W + HEAD_W;
  localparam int          CAT_W    = 2 * DATA_W;
  localparam logic [5:0]  SEQ_LAST = 6'd32;

  logic [5:0]              r_seq;
  logic                    r_valid;
  logic [LANE_N*DATA_W-1:0] r_data;
  logic [DATA_W-1:0]       r_res [LANE_N];

  logic                    w_ready;
  logic [7:0]              w_shamt;
  logic [BLK_W-1:0]        w_blk [LANE_N];
  logic [CAT_W-1:0]        w_cat [LANE_N];

  assign w_ready = (r_seq != SEQ_LAST);
  assign w_shamt = 8'(r_seq * HEAD_W);

  // Residue holds 2k bits at seq=k, so the newest block never reaches past bit 127.
  always_comb begin
    for (int l = 0; l < LANE_N; l++) begin
      w_blk[l] = {bus.data_i[l*DATA_W +: DATA_W], bus.head_i[l*HEAD_W +: HEAD_W]};
      w_cat[l] = ({{(CAT_W-BLK_W){1'b0}}, w_blk[l]} << w_shamt)
               | {{(CAT_W-DATA_W){1'b0}}, r_res[l]};
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_seq   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      for (int l = 0; l < LANE_N; l++) begin
        r_res[l] <= '0;
      end
    end else begin
      r_seq   <= (r_seq == SEQ_LAST) ? 6'd0 : r_seq + 6'd1;
      r_valid <= 1'b1;
      for (int l = 0; l < LANE_N; l++) begin
        if (r_seq == SEQ_LAST) begin
          r_data[l*DATA_W +: DATA_W] <= r_res[l];
          r_res[l]                   <= '0;
        end else begin
          r_data[l*DATA_W +: DATA_W] <= w_cat[l][DATA_W-1:0];
          r_res[l]                   <= w_cat[l][CAT_W-1:DATA_W];
        end
      end
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;

`ifdef GEARBOX_TX_SEQ_O_EN
  assign seq_o = r_seq;

  always_ff @(posedge clk) begin
    if (nreset) begin
      assert (r_seq <= SEQ_LAST);
    end
  end
`endif

endmodule

// File: tb/tb_gearbox_tx.sv
// Directed bench for gearbox_tx: stall cadence, fixed patterns, random bit-stream model, mid-period reset.
// Builds with or without GEARBOX_TX_SEQ_O_EN; seq_o is checked only when the macro is defined.
module tb_gearbox_tx;

  localparam int LANE_N = 4;
  localparam int HEAD_W = 2;
  localparam int DATA_W = 64;

  logic clk;
  logic nreset;
`ifdef GEARBOX_TX_SEQ_O_EN
  logic [5:0] seqO;
`endif

  int checkCount;
  int passCount;

  gearbox_tx_if #(.LANE_N(LANE_N), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) bus ();

  gearbox_tx #(.LANE_N(LANE_N), .HEAD_W(HEAD_W), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .nreset (nreset),
`ifdef GEARBOX_TX_SEQ_O_EN
    .seq_o  (seqO),
`endif
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [LANE_N*HEAD_W-1:0] head,
                               input logic [LANE_N*DATA_W-1:0] data);
    bus.head_i = head;
    bus.data_i = data;
  endtask

  task automatic resetDut();
    nreset = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    applyStimulus('0, '0);
    nreset = 1'b0;
    tick();
    tick();
    checkCount++;
    if (bus.data_o !== '0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      $display("[TB] FAIL reset_state: data_o=%h valid_o=%b ready_o=%b, required 0/0/1",
               bus.data_o, bus.valid_o, bus.ready_o);
    end else begin
      passCount++;
    end
    nreset = 1'b1;
  endtask

  task automatic test_cadence();
    logic expReady;
    logic expValid;
    applyStimulus('0, '0);
    resetDut();
    for (int c = 0; c < 99; c++) begin
      expReady = ((c % 33) != 32);
      expValid = (c != 0);
      checkCount++;
      if (bus.ready_o !== expReady || bus.valid_o !== expValid) begin
        $display("[TB] FAIL cadence cycle %0d: ready_o=%b valid_o=%b, required %b/%b",
                 c, bus.ready_o, bus.valid_o, expReady, expValid);
      end else begin
        passCount++;
      end
`ifdef GEARBOX_TX_SEQ_O_EN
      checkCount++;
      if (seqO !== 6'(c % 33)) begin
        $display("[TB] FAIL seq_o cycle %0d: got %0d, required %0d", c, seqO, c % 33);
      end else begin
        passCount++;
      end
`endif
      tick();
    end
  endtask

  task automatic test_sync_pattern();
    logic [DATA_W-1:0]        word;
    logic [LANE_N*DATA_W-1:0] expData;
    applyStimulus({LANE_N{2'b01}}, '0);
    resetDut();
    for (int c = 0; c < 66; c++) begin
      tick();
      word    = ((c % 33) == 32) ? 64'h0 : (64'h1 << (2 * (c % 33)));
      expData = {LANE_N{word}};
      checkCount++;
      if (bus.data_o !== expData || bus.valid_o !== 1'b1) begin
        $display("[TB] FAIL sync_word %0d: data_o=%h valid_o=%b, required %h/1",
                 c, bus.data_o, bus.valid_o, expData);
      end else begin
        passCount++;
      end
    end
  endtask

  task automatic test_ones_lane0();
    logic [LANE_N*DATA_W-1:0] expData;
    applyStimulus({6'b0, 2'b10}, {192'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    resetDut();
    for (int c = 0; c < 33; c++) begin
      tick();
      if (c == 0 || c == 1 || c == 32) begin
        case (c)
          0:       expData = {192'h0, 64'hFFFF_FFFF_FFFF_FFFE};
          1:       expData = {192'h0, 64'hFFFF_FFFF_FFFF_FFFB};
          default: expData = {192'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        endcase
        checkCount++;
        if (bus.data_o !== expData) begin
          $display("[TB] FAIL ones_word %0d: data_o=%h, required %h", c, bus.data_o, expData);
        end else begin
          passCount++;
        end
      end
    end
  endtask

  // Reference is a plain per-lane bit FIFO: 66 bits in per accepted block, 64 bits out per word.
  task automatic test_random_stream();
    bit                       laneQ [LANE_N][$];
    logic [LANE_N*HEAD_W-1:0] head;
    logic [LANE_N*DATA_W-1:0] data;
    logic [DATA_W+HEAD_W-1:0] blk;
    logic [DATA_W-1:0]        expWord;
    logic [DATA_W-1:0]        gotWord;
    resetDut();
    for (int c = 0; c < 99; c++) begin
      for (int l = 0; l < LANE_N; l++) begin
        head[l*HEAD_W +: HEAD_W] = 2'($urandom_range(0, 3));
        data[l*DATA_W +: DATA_W] = {$urandom, $urandom};
      end
      applyStimulus(head, data);
      if ((c % 33) != 32) begin
        for (int l = 0; l < LANE_N; l++) begin
          blk = {data[l*DATA_W +: DATA_W], head[l*HEAD_W +: HEAD_W]};
          for (int b = 0; b < DATA_W + HEAD_W; b++) laneQ[l].push_back(blk[b]);
        end
      end
      tick();
      for (int l = 0; l < LANE_N; l++) begin
        expWord = '0;
        if (laneQ[l].size() >= DATA_W) begin
          for (int b = 0; b < DATA_W; b++) expWord[b] = laneQ[l].pop_front();
        end
        gotWord = bus.data_o[l*DATA_W +: DATA_W];
        checkCount++;
        if (gotWord !== expWord) begin
          $display("[TB] FAIL random lane %0d word %0d: data_o=%h, required %h",
                   l, c, gotWord, expWord);
        end else begin
          passCount++;
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    applyStimulus({LANE_N{2'b01}}, '0);
    resetDut();
    for (int c = 0; c < 17; c++) tick();
    checkCount++;
    if (bus.data_o !== {LANE_N{64'h1 << 32}}) begin
      $display("[TB] FAIL pre_reset word16: data_o=%h, required %h", bus.data_o, {LANE_N{64'h1 << 32}});
    end else begin
      passCount++;
    end
    nreset = 1'b0;
    tick();
    checkCount++;
    if (bus.data_o !== '0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      $display("[TB] FAIL mid_reset: data_o=%h valid_o=%b ready_o=%b, required 0/0/1",
               bus.data_o, bus.valid_o, bus.ready_o);
    end else begin
      passCount++;
    end
    nreset = 1'b1;
    tick();
    checkCount++;
    if (bus.data_o !== {LANE_N{64'h1}} || bus.valid_o !== 1'b1) begin
      $display("[TB] FAIL post_reset word0: data_o=%h valid_o=%b, required %h/1",
               bus.data_o, bus.valid_o, {LANE_N{64'h1}});
    end else begin
      passCount++;
    end
    tick();
    checkCount++;
    if (bus.data_o !== {LANE_N{64'h4}}) begin
      $display("[TB] FAIL post_reset word1: data_o=%h, required %h", bus.data_o, {LANE_N{64'h4}});
    end else begin
      passCount++;
    end
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    nreset     = 1'b0;
    applyStimulus('0, '0);
    $display("[TB] gearbox_tx bench start");
    test_reset();
    test_cadence();
    test_sync_pattern();
    test_ones_lane0();
    test_random_stream();
    test_mid_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
